// File: rtl/bank_access_sequencer_if.sv
// bank_access_sequencer_if: client/bank signal bundle for bank_access_sequencer
//   req       requester -> sequencer  level request per requester
//   req_addr  requester -> sequencer  word address, requester i at [i*ADDR_W +: ADDR_W]
//   req_we    requester -> sequencer  1 = write, 0 = read
//   grant     sequencer -> requester  one-hot current owner, 0 when idle
//   sel       sequencer -> decoder    registered word select
//   wl_en     sequencer -> bank       word-line enable
//   we        sequencer -> bank       write enable, valid while wl_en=1
//   done      sequencer -> requester  1-cycle completion pulse to owner
//   err       sequencer -> requester  1-cycle out-of-range reject pulse
//   busy      sequencer -> requester  high whenever an access is in flight
interface bank_access_sequencer_if #(
   parameter int NREQ   = 4,
   parameter int ADDR_W = 10
);
   logic [NREQ-1:0]        req;
   logic [NREQ*ADDR_W-1:0] req_addr;
   logic [NREQ-1:0]        req_we;
   logic [NREQ-1:0]        grant;
   logic [ADDR_W-1:0]      sel;
   logic                   wl_en;
   logic                   we;
   logic [NREQ-1:0]        done;
   logic [NREQ-1:0]        err;
   logic                   busy;
   modport master (output req, req_addr, req_we,
                   input  grant, sel, wl_en, we, done, err, busy);
   modport slave  (input  req, req_addr, req_we,
                   output grant, sel, wl_en, we, done, err, busy);
endinterface

// File: rtl/bank_access_sequencer.sv
// bank_access_sequencer: round-robin sharing of one bank's word-line decoder,
// sequencing each access through settle, word-line-enable and recovery phases.
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   bus    slave side of bank_access_sequencer_if (requests in; grant, sel,
//          wl_en, we, done, err, busy out)
module bank_access_sequencer #(
   parameter int NREQ          = 4,
   parameter int ADDR_W        = 10,
   parameter int DEPTH         = 1024,
   parameter int SETTLE_CYCLES = 2,
   parameter int HOLD_CYCLES   = 1
) (
   input logic clk,
   input logic rst_n,
   bank_access_sequencer_if.slave bus
);
   localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
   typedef enum logic [2:0] {IDLE, REJECT, SETUP, ACTIVE, RECOVER} state_t;
   state_t            state, nxt;
   logic [PW-1:0]     rr_ptr, off, win, rr_nxt;
   logic [PW:0]       sum;
   logic [NREQ-1:0]   rot, win_oh, grant_q, done_q, err_q, done_d, err_d;
   logic [ADDR_W-1:0] win_addr, sel_q;
   logic [15:0]       cnt;
   logic              win_we, we_lat, in_range, settle_end, hold_end;
   logic              wl_en_q, we_q, busy_q, wl_en_d, we_d, busy_d;
   // Rotate requests so bit 0 is the requester at rr_ptr; the lowest set bit
   // of the rotated vector is the round-robin winner.
   always_comb begin
      rot = NREQ'({bus.req, bus.req} >> rr_ptr);
      off = '0;
      for (int i = NREQ - 1; i >= 0; i--)
         if (rot[i]) off = PW'(i);
      sum = {1'b0, rr_ptr} + {1'b0, off};
      win = sum >= (PW+1)'(NREQ) ? PW'(sum - (PW+1)'(NREQ)) : PW'(sum);
      win_oh = NREQ'(1) << win;
      rr_nxt = win == PW'(NREQ - 1) ? '0 : win + 1'b1;
      win_addr = '0;
      win_we = 1'b0;
      for (int i = 0; i < NREQ; i++)
         if (win_oh[i]) begin
            win_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
            win_we = bus.req_we[i];
         end
      in_range = int'(win_addr) < DEPTH;
      settle_end = cnt == 16'(SETTLE_CYCLES - 1);
      hold_end = cnt == 16'(HOLD_CYCLES - 1);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state   <= IDLE;
         rr_ptr  <= '0;
         cnt     <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         we_lat  <= 1'b0;
         wl_en_q <= 1'b0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= '0;
         err_q   <= '0;
      end else begin
         state   <= nxt;
         cnt     <= state == nxt && (state == SETUP || state == ACTIVE) ? cnt + 1'b1 : '0;
         wl_en_q <= wl_en_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         if (state == IDLE && |bus.req) begin
            grant_q <= win_oh;
            rr_ptr  <= rr_nxt;
            we_lat  <= win_we;
            if (in_range) sel_q <= win_addr;
         end else if (state == REJECT || state == RECOVER)
            grant_q <= '0;
      end
   always_comb begin
      nxt = state;
      case (state)
         IDLE:            nxt = |bus.req ? (in_range ? SETUP : REJECT) : IDLE;
         SETUP:           nxt = settle_end ? ACTIVE : SETUP;
         ACTIVE:          nxt = hold_end ? RECOVER : ACTIVE;
         REJECT, RECOVER: nxt = IDLE;
         default:         nxt = IDLE;
      endcase
   end
   // Outputs are registered from the next state so the bank sees glitch-free
   // strobes that line up exactly with the state they belong to.
   always_comb begin
      busy_d  = nxt != IDLE;
      wl_en_d = nxt == ACTIVE;
      we_d    = nxt == ACTIVE && we_lat;
      done_d  = nxt == RECOVER ? grant_q : '0;
      err_d   = nxt == REJECT ? win_oh : '0;
   end
   assign bus.grant = grant_q;
   assign bus.sel   = sel_q;
   assign bus.wl_en = wl_en_q;
   assign bus.we    = we_q;
   assign bus.done  = done_q;
   assign bus.err   = err_q;
   assign bus.busy  = busy_q;
endmodule
